parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver and parity checker. It takes a bit stream (one bit per `bit_valid` strobe), detects a start bit, and assembles `DATA_W` data bits. It then recomputes their XOR parity, compares it with the received parity bit, and checks the stop bit. It is the receive end of the team's XOR parity generator / serial framer, and delivers each frame as a parallel word with error flags.

## Interface
- `DATA_W`, default 8: number of data bits per frame; legal range 1..32.

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `bit_in`  in  1: serial line bit; sampled only when `bit_valid`=1.
- `bit_valid`  in  1: one-cycle strobe, one per line bit; any gap length allowed.
- `data_out`  out  DATA_W: received data word, LSB is the first data bit received.
- `data_valid`  out  1: one-cycle pulse; `data_out` and the error flags are updated in this cycle.
- `parity_err`  out  1: received parity mismatched the computed parity.
- `frame_err`  out  1: stop bit was 0.
- `busy`  out  1: a frame is in progress (state is not IDLE).

## Operation
- Frame on the line, in consumed order:
  - start bit (0);
  - `DATA_W` data bits, LSB first;
  - parity bit;
  - stop bit (1).
- Only cycles with `bit_valid`=1 advance the state machine. Cycles with `bit_valid`=0 hold all state.
- States:
  - IDLE: `bit_valid`&&`bit_in`=0 → DATA, clearing the bit counter, shift register and running parity. `bit_in`=1 is idle line and is ignored.
  - DATA: shift `bit_in` into the MSB end of a DATA_W shift register, so after DATA_W shifts the first bit sits at bit 0. Update running parity as parity ^ `bit_in`. Increment a counter of width clog2(DATA_W)+1. After the DATA_W-th bit → PARITY.
  - PARITY: latch mismatch = (running parity ^ `bit_in`) != expected, where expected is 0 for even parity and 1 for odd parity. → STOP.
  - STOP: latch frame error = (`bit_in`==0). Register `data_out` and the flags, and pulse `data_valid`. → IDLE.
- A frame is delivered even with errors; the flags indicate which check failed. Both flags may be 1 at once.
- `data_out`, `parity_err` and `frame_err` hold their values until the next delivery. They are meaningful only on or after a `data_valid` pulse.
- `busy`=1 in DATA, PARITY and STOP.
- There is no output backpressure; the consumer must take `data_out` on `data_valid`.

## Timing
- Reset (asynchronous assert, deassert synchronized externally): state IDLE; `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0; counter, shift register and running parity all 0.
- Reset mid-frame discards the partial frame. No `data_valid` is produced for it.
- Latency: `data_valid` is high in the cycle after the clock edge that samples the stop bit. All outputs are registered.
- `busy` rises the cycle after the start bit is sampled and falls together with the `data_valid` pulse.
- Back-to-back frames: the FSM is in IDLE in the `data_valid` cycle. A start bit strobed in that same cycle is accepted with no lost bit.
- A 0 on the line in IDLE is always a start bit. There is no false-start filtering and no resynchronization within a frame.

## Configuration
- `PARITY_ODD_EN` defined: odd parity. The XOR of the data bits and the parity bit must equal 1.
- `PARITY_ODD_EN` undefined (default): even parity. The XOR of the data bits and the parity bit must equal 0.
- The macro changes only the expected-parity constant. The interface is unchanged.

## Test plan
- Even build, DATA_W=8: send 0,[A5 LSB first],0,1 with contiguous strobes → one `data_valid` pulse, `data_out`=0xA5, `parity_err`=0, `frame_err`=0, `busy` low afterwards.
- Even build: send 0x3C with parity 1 → `data_out`=0x3C, `parity_err`=1, `frame_err`=0. Odd build: same stimulus → `parity_err`=0.
- Send 0xFF, parity 0, stop 0 → `data_out`=0xFF, `parity_err`=0, `frame_err`=1. The next frame 0x01 (parity 1), sent immediately, → `data_valid` with `data_out`=0x01 and `parity_err`=0, and `frame_err` cleared to 0.
- Random gaps of 0–5 idle cycles between strobes, plus idle-line 1s before the start bit, for 0x5A → same result as the contiguous case. No `data_valid` is produced before the stop strobe.
- Assert `rst_n`=0 after the 4th data bit, release, then send full frame 0x81 → only one `data_valid`, with `data_out`=0x81. All outputs are 0 during reset.
- Two frames with the second start bit strobed in the first frame's `data_valid` cycle → two pulses, with values 0x12 then 0x34.

Source files
------------

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver (start, DATA_W data LSB first, parity, stop) with parity/stop checks.
// Define PARITY_ODD_EN for odd parity; default build checks even parity.
module parity_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W) + 1;
`ifdef PARITY_ODD_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              par;
    logic              perr;

    always_comb begin
        state_next = state;
        if (bit_valid) begin
            case (state)
                IDLE:    state_next = bit_in ? IDLE : DATA;
                DATA:    state_next = (cnt == CW'(DATA_W - 1)) ? PARITY : DATA;
                PARITY:  state_next = STOP;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            data_valid <= 1'b0;
            busy       <= (state_next != IDLE);
            if (bit_valid) begin
                case (state)
                    IDLE: if (!bit_in) begin
                        cnt   <= '0;
                        shreg <= '0;
                        par   <= 1'b0;
                    end
                    DATA: begin
                        // first data bit ends up at bit 0 after DATA_W shifts
                        shreg <= (shreg >> 1) | (DATA_W'(bit_in) << (DATA_W - 1));
                        par   <= par ^ bit_in;
                        cnt   <= cnt + 1'b1;
                    end
                    PARITY: perr <= ((par ^ bit_in) != PAR_EXP);
                    default: begin
                        data_out   <= shreg;
                        parity_err <= perr;
                        frame_err  <= ~bit_in;
                        data_valid <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: randomized scoreboard bench for parity_frame_rx.
module tb_parity_frame_rx;
    localparam int DATA_W = 8;
`ifdef PARITY_ODD_EN
    localparam int ODD = 1;
`else
    localparam int ODD = 0;
`endif

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              pe;
        logic              fe;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bit_in = 1'b1;
    logic              bit_valid = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   frames_sent = 0;
    int   pulses = 0;

    parity_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic strobe(input logic b, input int maxgap);
        repeat ($urandom_range(0, maxgap)) begin
            @(posedge clk);
            #1;
        end
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                              input int maxgap, input int idle_ones);
        exp_t e;
        repeat (idle_ones) strobe(1'b1, maxgap);
        strobe(1'b0, maxgap);
        for (int i = 0; i < DATA_W; i++) strobe(d[i], maxgap);
        strobe(p, maxgap);
        strobe(s, maxgap);
        e.d  = d;
        e.pe = ((($countones(d) + int'(p)) % 2) != ODD);
        e.fe = ~s;
        sb.push_back(e);
        frames_sent++;
    endtask

    function automatic logic good_par(input logic [DATA_W-1:0] d);
        return logic'((($countones(d) % 2) != ODD));
    endfunction

    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%h required=none", data_out);
            end else begin
                e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                check("frame_err", 32'(frame_err), 32'(e.fe));
                check("busy_on_valid", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #12;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("busy_after_a5", 32'(busy), 32'd0);

        send_frame(8'h3C, 1'b1, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b0, 1'b0, 0, 0);
        send_frame(8'h01, 1'b1, 1'b1, 0, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 5, 3);

        strobe(1'b0, 0);
        strobe(1'b1, 0);
        check("busy_mid_frame", 32'(busy), 32'd1);
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b1, 0);
        rst_n = 1'b0;
        #2;
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_parity_err", 32'(parity_err), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h81, good_par(8'h81), 1'b1, 0, 0);

        send_frame(8'h12, good_par(8'h12), 1'b1, 0, 0);
        send_frame(8'h34, good_par(8'h34), 1'b1, 0, 0);

        for (int n = 0; n < 40; n++)
            send_frame(DATA_W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 3), $urandom_range(0, 2));

        repeat (5) @(posedge clk);
        #1;
        check("busy_final", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(frames_sent));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
